// File: rtl/bit_word_packer_param.sv
// rtl/bit_word_packer_param.sv - packs popped upstream bits MSB-first into a word on each request edge
module bit_word_packer_param #(
    parameter int   WORD_W       = 12,
    parameter int   READY_CYCLES = 4,
    parameter logic PAD_BIT      = 1'b0,
    parameter int   STICKY_PAD   = 1,
    parameter int   CNT_W        = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_bit_data,
    input  logic                         i_bit_buf_empty,
    output logic                         o_bit_request,
    input  logic                         i_data_request,
    output logic [WORD_W-1:0]            o_data,
    output logic                         o_data_ready,
    output logic                         o_word_padded,
    output logic [$clog2(WORD_W+1)-1:0]  o_pad_count,
    output logic [CNT_W-1:0]             o_underrun_cnt,
    output logic                         o_rq_missed
);
    localparam int PC_W  = $clog2(WORD_W + 1);
    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_WRITE, S_PRESENT} state_t;

    state_t              r_state;
    logic [2:0]          r_sync;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_pad_active;
    logic [PC_W-1:0]     r_pad_cnt;
    logic                r_bit;
    logic [WORD_W-1:0]   r_shreg;
    logic [WORD_W-1:0]   r_data;
    logic                r_data_ready;
    logic                r_word_padded;
    logic [PC_W-1:0]     r_pad_count;
    logic [CNT_W-1:0]    r_underrun;
    logic [7:0]          r_ready_cnt;
    logic                r_rq_missed;

    logic w_rq_edge;
    logic w_pad_pick;

    assign w_rq_edge  = r_sync[1] & ~r_sync[2];
    // With STICKY_PAD=0 only the live empty flag decides, so data and pad bits may interleave.
    assign w_pad_pick = ((STICKY_PAD != 0) && r_pad_active) || i_bit_buf_empty;

    // Pop is a decode of PICK so it lines up with the edge that captures i_bit_data.
    assign o_bit_request  = (r_state == S_PICK) && !w_pad_pick;
    assign o_data         = r_data;
    assign o_data_ready   = r_data_ready;
    assign o_word_padded  = r_word_padded;
    assign o_pad_count    = r_pad_count;
    assign o_underrun_cnt = r_underrun;
    assign o_rq_missed    = r_rq_missed;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_sync        <= '0;
            r_bit_idx     <= '0;
            r_pad_active  <= 1'b0;
            r_pad_cnt     <= '0;
            r_bit         <= 1'b0;
            r_shreg       <= '0;
            r_data        <= '0;
            r_data_ready  <= 1'b0;
            r_word_padded <= 1'b0;
            r_pad_count   <= '0;
            r_underrun    <= '0;
            r_ready_cnt   <= '0;
            r_rq_missed   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[1:0], i_data_request};
            r_rq_missed <= w_rq_edge && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_bit_idx    <= IDX_W'(WORD_W - 1);
                    r_pad_active <= 1'b0;
                    r_pad_cnt    <= '0;
                    if (w_rq_edge) begin
                        r_state <= S_PICK;
                    end
                end
                S_PICK: begin
                    if (w_pad_pick) begin
                        r_bit        <= PAD_BIT;
                        r_pad_cnt    <= r_pad_cnt + PC_W'(1);
                        r_pad_active <= 1'b1;
                    end else begin
                        r_bit <= i_bit_data;
                    end
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_shreg[r_bit_idx] <= r_bit;
                    if (r_bit_idx == '0) begin
                        r_data        <= {r_shreg[WORD_W-1:1], r_bit};
                        r_word_padded <= (r_pad_cnt != '0);
                        r_pad_count   <= r_pad_cnt;
                        r_data_ready  <= 1'b1;
                        r_ready_cnt   <= '0;
                        r_state       <= S_PRESENT;
                    end else begin
                        r_bit_idx <= r_bit_idx - IDX_W'(1);
                        r_state   <= S_PICK;
                    end
                end
                S_PRESENT: begin
                    if ((r_ready_cnt == 8'd0) && r_word_padded && (r_underrun != {CNT_W{1'b1}})) begin
                        r_underrun <= r_underrun + CNT_W'(1);
                    end
                    if (r_ready_cnt == 8'(READY_CYCLES - 1)) begin
                        r_data_ready <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_ready_cnt <= r_ready_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_word_packer_param.sv
// tb/tb_bit_word_packer_param.sv - directed and random checks of the bit-to-word packer against a queue model
module tb_bit_word_packer_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        bit_data;
    logic        bit_buf_empty;
    logic        bit_request;
    logic        data_request;
    logic [11:0] data;
    logic        data_ready;
    logic        word_padded;
    logic [3:0]  pad_count;
    logic [3:0]  underrun;
    logic        rq_missed;

    bit_word_packer_param #(
        .WORD_W(12), .READY_CYCLES(4), .PAD_BIT(1'b0), .STICKY_PAD(0), .CNT_W(4)
    ) u_dut (
        .i_clk(clk), .i_reset(reset), .i_bit_data(bit_data), .i_bit_buf_empty(bit_buf_empty),
        .o_bit_request(bit_request), .i_data_request(data_request), .o_data(data),
        .o_data_ready(data_ready), .o_word_padded(word_padded), .o_pad_count(pad_count),
        .o_underrun_cnt(underrun), .o_rq_missed(rq_missed)
    );

    always #5 clk = ~clk;

    bit q[$];
    bit mq[$];
    int pops = 0;
    int missed_cnt = 0;
    int gap_at = -1;
    int gap_left = 0;
    bit pop_pending = 0;
    int checks = 0;
    int errors = 0;
    int m_under = 0;
    int last_lat, last_hi, last_pops;

    // Upstream buffer: pops seen on the falling edge take effect just after the next rising edge.
    always @(negedge clk) begin
        pop_pending = bit_request;
        if (rq_missed) missed_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_pending && q.size() > 0) begin
            void'(q.pop_front());
            pops++;
            if (pops == gap_at) gap_left = 4;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        pop_pending   = 0;
        bit_buf_empty = (q.size() == 0) || (gap_left > 0);
        bit_data      = (q.size() > 0) ? q[0] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            q.push_back(v[i]);
            mq.push_back(v[i]);
        end
    endtask

    task automatic model_word(output logic [11:0] d, output int pc, output int np);
        d = '0; pc = 0; np = 0;
        for (int i = 0; i < 12; i++) begin
            d = d << 1;
            if (mq.size() > 0) begin
                d[0] = mq.pop_front();
                np++;
            end else begin
                pc++;
            end
        end
        if (pc > 0 && m_under < 15) m_under++;
    endtask

    task automatic do_word();
        int p0;
        p0 = pops;
        @(negedge clk) data_request = 1'b1;
        last_lat = 0;
        do begin
            @(posedge clk); #1;
            last_lat++;
        end while (!data_ready && last_lat < 80);
        last_hi = 0;
        while (data_ready && last_hi < 300) begin
            last_hi++;
            @(posedge clk); #1;
        end
        last_pops = pops - p0;
        @(negedge clk) data_request = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_checked(input string tag);
        logic [11:0] ed;
        int epc, enp;
        model_word(ed, epc, enp);
        do_word();
        check({tag, "_seen"}, (last_lat < 80), 1);
        check({tag, "_data"}, data, ed);
        check({tag, "_padded"}, word_padded, (epc != 0));
        check({tag, "_padcnt"}, pad_count, epc);
        check({tag, "_pops"}, last_pops, enp);
        check({tag, "_hi"}, last_hi, 4);
        check({tag, "_under"}, underrun, m_under);
    endtask

    initial begin
        int n;
        reset = 1'b0; data_request = 1'b0; bit_data = 1'b0; bit_buf_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_ready", data_ready, 0);
        check("rst_req", bit_request, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_under", underrun, 0);

        push_bits(32'hA5C, 12);
        run_checked("t1");
        check("t1_lat", last_lat, 27);
        check("t1_const", data, 12'hA5C);

        push_bits(32'b10110, 5);
        run_checked("t2");
        check("t2_const", {data, pad_count, underrun}, {12'hB00, 4'd7, 4'd1});

        push_bits(32'h3FF, 10);
        for (int i = 0; i < 10; i++) void'(mq.pop_front());
        gap_at = pops + 7;
        do_word();
        gap_at = -1;
        m_under++;
        check("t3_data", data, 12'hFE7);
        check("t3_padcnt", pad_count, 2);
        check("t3_pops", last_pops, 10);
        check("t3_under", underrun, m_under);

        push_bits($urandom_range(0, 4095), 12);
        begin
            logic [11:0] ed;
            int epc, enp, t, seen2;
            model_word(ed, epc, enp);
            missed_cnt = 0;
            @(negedge clk) data_request = 1'b1;
            repeat (4) @(negedge clk);
            data_request = 1'b0;
            repeat (8) @(negedge clk);
            data_request = 1'b1;
            t = 0;
            while (!data_ready && t < 80) begin @(negedge clk); t++; end
            check("t4_seen", (t < 80), 1);
            repeat (6) @(negedge clk);
            check("t4_data", data, ed);
            seen2 = 0;
            repeat (50) begin @(negedge clk); if (data_ready) seen2 = 1; end
            check("t4_second", seen2, 0);
            check("t4_missed", missed_cnt, 1);
            data_request = 1'b0;
            repeat (4) @(negedge clk);
        end

        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(0, 14);
            push_bits($urandom, n);
            run_checked("rnd");
        end

        while (q.size() > 0) begin void'(q.pop_front()); void'(mq.pop_front()); end
        push_bits($urandom_range(0, 4095), 12);
        begin
            int p0, t;
            p0 = pops;
            @(negedge clk) data_request = 1'b1;
            t = 0;
            do begin @(posedge clk); #2; t++; end while (pops < p0 + 6 && t < 100);
            check("t5_reach", pops - p0, 6);
            reset = 1'b0;
            #1;
            check("t5_async", {data, data_ready, word_padded, pad_count, underrun, rq_missed, bit_request}, 0);
            for (int i = 0; i < 6; i++) void'(mq.pop_front());
            m_under = 0;
            data_request = 1'b0;
            repeat (3) @(negedge clk);
            check("t5_hold", {data, data_ready, bit_request}, 0);
            reset = 1'b1;
            repeat (3) @(negedge clk);
        end
        push_bits($urandom_range(0, 4095), 12);
        run_checked("t5_next");
        check("t5_clean", {word_padded, last_pops}, {1'b0, 32'd12});

        for (int k = 0; k < 17; k++) run_checked("t6");
        check("t6_sat", underrun, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
